lut_layer_tdm: RTL and testbench

// Parametrised, time-multiplexed LUT neuron layer for the quantised LUT-network datapath.

---
 rtl/lut_layer_tdm_if.sv | 31 +++
 rtl/lut_layer_tdm.sv | 138 +++++++++++++
 tb/tb_lut_layer_tdm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_tdm_if.sv
// Handshake, result and LUT-configuration bundle for lut_layer_tdm.
// The master side feeds features and config writes; the slave side is the layer.
interface lut_layer_tdm_if #(
  parameter int unsigned IN_FEATS  = 32,
  parameter int unsigned BW        = 4,
  parameter int unsigned FANIN     = 3,
  parameter int unsigned N_NEURONS = 5,
  parameter int unsigned NIDW      = 3
);
  logic                        in_valid;
  logic                        in_ready;
  logic [IN_FEATS*BW-1:0]      in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_NEURONS*BW-1:0]     out_data;
  logic                        busy;
  logic                        cfg_we;
  logic [NIDW+FANIN*BW-1:0]    cfg_addr;
  logic [BW-1:0]               cfg_data;
  logic                        cfg_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, busy, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, busy, cfg_err
  );
endinterface

// File: rtl/lut_layer_tdm.sv
// Time-multiplexed sparse LUT neuron layer: one neuron per cycle through a shared
// synchronous LUT RAM, with valid/ready streaming and a runtime LUT config port.
module lut_layer_tdm #(
  parameter int unsigned IN_FEATS  = 32,
  parameter int unsigned BW        = 4,
  parameter int unsigned FANIN     = 3,
  parameter int unsigned N_NEURONS = 5,
  parameter int unsigned IDXW      = 5,
  parameter int unsigned NIDW      = 3,
  parameter logic [N_NEURONS*FANIN*IDXW-1:0] CONN = {5'd25, 5'd6, 5'd4, 5'd22, 5'd17, 5'd3,
                                                     5'd23, 5'd14, 5'd5, 5'd24, 5'd10, 5'd7,
                                                     5'd26, 5'd6, 5'd0},
  parameter string LUT_INIT = ""
) (
  input logic            clk,
  input logic            rst,
  lut_layer_tdm_if.slave bus
);
  localparam int unsigned FeatW    = FANIN * BW;
  localparam int unsigned AddrW    = NIDW + FeatW;
  localparam int unsigned LutWords = N_NEURONS * (2 ** FeatW);
  localparam int unsigned CntW     = $clog2(N_NEURONS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IN_FEATS*BW-1:0]  feat_q, feat_d;
  logic [N_NEURONS*BW-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    cfg_err_q, cfg_err_d;

  logic [FeatW-1:0]        sel_feat;
  logic [AddrW-1:0]        raddr;
  logic                    re, we, in_ready, cfg_open, cfg_in_range;
  logic [BW-1:0]           rdata_q;
  logic [BW-1:0]           lut_ram [LutWords];

  // Gather the fanin features of neuron cnt_q; fanin 0 lands in the MSBs.
  always_comb begin
    sel_feat = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (cnt_q == CntW'(k)) begin
        for (int j = 0; j < FANIN; j++) begin
          sel_feat[(FANIN-1-j)*BW +: BW] = feat_q[CONN[(k*FANIN+j)*IDXW +: IDXW]*BW +: BW];
        end
      end
    end
  end

  assign raddr        = {NIDW'(cnt_q), sel_feat};
  assign cfg_open     = (state_q == StIdle) || (state_q == StDone);
  assign cfg_in_range = ({1'b0, bus.cfg_addr} < (AddrW+1)'(LutWords));
  assign we           = bus.cfg_we && cfg_open && cfg_in_range;

  // Writes only happen outside RUN, so they can never collide with a read.
  always_ff @(posedge clk) begin
    if (we) lut_ram[bus.cfg_addr] <= bus.cfg_data;
    if (re) rdata_q <= lut_ram[raddr];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    feat_d      = feat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_err_q;
    re          = 1'b0;
    in_ready    = 1'b0;

    if (bus.cfg_we && !we) cfg_err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          feat_d  = bus.in_data;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        re    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // The word read last cycle belongs to neuron cnt_q-1.
        for (int k = 0; k < N_NEURONS - 1; k++) begin
          if (cnt_q == CntW'(k + 1)) out_data_d[k*BW +: BW] = rdata_q;
        end
        if (cnt_q == CntW'(N_NEURONS - 1)) state_d = StDrain;
      end
      StDrain: begin
        out_data_d[(N_NEURONS-1)*BW +: BW] = rdata_q;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          in_ready    = 1'b1;
          out_valid_d = 1'b0;
          if (bus.in_valid) begin
            feat_d  = bus.in_data;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      feat_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      feat_q      <= feat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == StRun) || (state_q == StDrain);
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_tdm.sv
// Scoreboard bench for lut_layer_tdm: stimulus pushes expected results, a monitor
// pops and compares on every out_valid/out_ready handshake.
module tb_lut_layer_tdm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [19:0] exp_q[$];

  lut_layer_tdm_if bus ();

  lut_layer_tdm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the handshake completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", bus.out_data);
        end else begin
          check("out_data", {44'd0, bus.out_data}, {44'd0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic logic [127:0] def_feats();
    logic [127:0] v;
    for (int f = 0; f < 32; f++) v[f*4 +: 4] = 4'(f % 16);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a transaction, wait for acceptance; e = cycle count of the accepting edge.
  task automatic send(input logic [127:0] d, input logic [19:0] exp, input bit push,
                      output int e);
    bit ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else if (push) begin
      exp_q.push_back(exp);
    end
    step();
    e            = cyc;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_out(input int e, output int lat, output int nbusy);
    nbusy = 0;
    lat   = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.out_valid) begin
        lat = cyc - e;
        break;
      end
    end
  endtask

  initial begin
    int e, lat, nbusy;
    logic [127:0] feats;
    feats         = def_feats();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;

    // 1: reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);

    // LUT[{k,a}] = k ^ a[3:0] over the whole table, last address included
    for (int a = 0; a < 20480; a++) begin
      step();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 15'(a);
      bus.cfg_data = 4'((a >> 12) ^ (a & 15));
    end
    step();
    bus.cfg_we = 1'b0;
    check("init_cfg_err", bus.cfg_err, 0);

    // 2: single transaction, busy spans 5 RUN cycles plus 1 DRAIN cycle
    bus.out_ready = 1'b1;
    send(feats, 20'hD559A, 1'b1, e);
    wait_out(e, lat, nbusy);
    check("t2_latency", lat, 6);
    check("t2_busy_cycles", nbusy, 6);

    // 3: backpressure then overlapped accept
    step();
    bus.out_ready = 1'b0;
    send(feats, 20'hD559A, 1'b1, e);
    wait_out(e, lat, nbusy);
    check("t3_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_data", bus.out_data, 20'hD559A);
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_in_ready", bus.in_ready, 0);
    end
    step();
    bus.out_ready = 1'b1;
    #1 check("t3_overlap_in_ready", bus.in_ready, 1);
    send(feats, 20'hD559A, 1'b1, e);
    check("t3_overlap_busy", bus.busy, 1);
    check("t3_overlap_valid", bus.out_valid, 0);
    wait_out(e, lat, nbusy);
    check("t3_overlap_latency", lat, 6);

    // 4: config write during RUN cycle 2 is dropped
    step();
    send(feats, 20'hD559A, 1'b1, e);
    step();
    step();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 15'h01A8;
    bus.cfg_data = 4'h3;
    step();
    bus.cfg_we = 1'b0;
    check("t4_cfg_err", bus.cfg_err, 1);
    wait_out(e, lat, nbusy);
    check("t4_latency", lat, 6);

    // 6: asynchronous reset at RUN cycle 3 abandons the transaction
    step();
    send(feats, 20'hD559A, 1'b0, e);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_cfg_err", bus.cfg_err, 0);
    check("t6_out_data", bus.out_data, 0);
    step();
    rst = 1'b0;
    step();
    send(feats, 20'hD559A, 1'b1, e);
    wait_out(e, lat, nbusy);
    check("t6_latency", lat, 6);

    // 5: config write in IDLE reaches neuron 0
    step();
    step();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 15'h006A;
    bus.cfg_data = 4'hF;
    step();
    bus.cfg_we = 1'b0;
    check("t5_cfg_err", bus.cfg_err, 0);
    send(feats, 20'hD559F, 1'b1, e);
    wait_out(e, lat, nbusy);

    // Config write on the accepting edge lands before the first read
    step();
    step();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 15'h006A;
    bus.cfg_data = 4'h1;
    send(feats, 20'hD5591, 1'b1, e);
    wait_out(e, lat, nbusy);
    check("t5b_latency", lat, 6);

    // Out-of-range config address is rejected
    step();
    step();
    check("oor_cfg_err_before", bus.cfg_err, 0);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 15'd20480;
    bus.cfg_data = 4'h7;
    step();
    bus.cfg_we = 1'b0;
    check("oor_cfg_err", bus.cfg_err, 1);

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
